// File: rtl/tmpl_pkg.sv
// rtl/tmpl_pkg.sv - default parameters, width helpers and line types for the window accumulator
package tmpl_pkg;

  localparam int PIXEL_SIZE_DEF    = 8;
  localparam int LINE_SIZE_DEF     = 8;
  localparam int NUM_TEMPLATES_DEF = 4;
  localparam int WINDOW_ROWS_DEF   = 8;

  function automatic int tree_depth(input int line_size);
    return $clog2(line_size);
  endfunction

  function automatic int sum_w(input int pixel_size, input int line_size);
    return 2 * pixel_size + $clog2(line_size);
  endfunction

  function automatic int acc_w(input int pixel_size, input int line_size, input int window_rows);
    return sum_w(pixel_size, line_size) + $clog2(window_rows);
  endfunction

  localparam int SUM_W      = sum_w(PIXEL_SIZE_DEF, LINE_SIZE_DEF);
  localparam int ACC_W      = acc_w(PIXEL_SIZE_DEF, LINE_SIZE_DEF, WINDOW_ROWS_DEF);
  localparam int TREE_DEPTH = tree_depth(LINE_SIZE_DEF);

  typedef logic [PIXEL_SIZE_DEF-1:0] pixel_t;
  typedef pixel_t line_t [LINE_SIZE_DEF];

endpackage

// File: rtl/pipelined_adder_tree.sv
// rtl/pipelined_adder_tree.sv - registered pairwise reduction of N unsigned operands with valid tracking
module pipelined_adder_tree #(
  parameter int IN_W = 8,
  parameter int N = 4,
  localparam int DEPTH = $clog2(N),
  localparam int OUT_W = IN_W + DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [N-1:0][IN_W-1:0]    in_data,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_sum
);

  localparam int LVW = 2 * N * OUT_W;

  // Each level is twice as wide as needed so the upper half reads as zeros,
  // which pairs any odd leftover element with 0 without special casing.
  typedef logic [2*N-1:0][OUT_W-1:0] level_t;

  level_t lv [DEPTH+1];
  logic [DEPTH:0] vld;
  logic [N-1:0][OUT_W-1:0] ext;

  always_comb begin
    ext = '0;
    for (int i = 0; i < N; i++) begin
      ext[i] = OUT_W'(in_data[i]);
    end
  end

  assign lv[0]  = LVW'(ext);
  assign vld[0] = in_valid;

  for (genvar l = 0; l < DEPTH; l++) begin : g_level
    logic [N-1:0][OUT_W-1:0] q;
    logic v;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
        v <= 1'b0;
      end else begin
        v <= clear ? 1'b0 : vld[l];
        for (int i = 0; i < N; i++) begin
          q[i] <= lv[l][2*i] + lv[l][2*i+1];
        end
      end
    end

    assign lv[l+1]  = LVW'(q);
    assign vld[l+1] = v;
  end

  if (DEPTH == 0) begin : g_flat
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, clear};
  end

  logic unused_hi;
  assign unused_hi = ^lv[DEPTH][2*N-1:1];

  assign out_sum   = lv[DEPTH][0];
  assign out_valid = vld[DEPTH];

endmodule

// File: rtl/template_window_accumulator.sv
// rtl/template_window_accumulator.sv - per-line I, I^2, TxI reduction accumulated over a window of valid lines
module template_window_accumulator
  import tmpl_pkg::*;
#(
  parameter int PIXEL_SIZE = PIXEL_SIZE_DEF,
  parameter int LINE_SIZE = LINE_SIZE_DEF,
  parameter int NUM_TEMPLATES = NUM_TEMPLATES_DEF,
  parameter int WINDOW_ROWS = WINDOW_ROWS_DEF,
  localparam int DEPTH = tree_depth(LINE_SIZE),
  localparam int LINE_SUM_W = sum_w(PIXEL_SIZE, LINE_SIZE),
  localparam int WIN_SUM_W = acc_w(PIXEL_SIZE, LINE_SIZE, WINDOW_ROWS),
  localparam int CNT_W = $clog2(WINDOW_ROWS + 1)
) (
  input  logic                                                    CLK,
  input  logic                                                    RST,
  input  logic                                                    in_clear,
  input  logic                                                    in_valid,
  input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                    I_in_line,
  input  logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][PIXEL_SIZE-1:0] T_in_line,
  output logic                                                    out_valid,
  output logic [WIN_SUM_W-1:0]                                    I_square_win_sum,
  output logic [WIN_SUM_W-1:0]                                    I_win_sum,
  output logic [NUM_TEMPLATES-1:0][WIN_SUM_W-1:0]                 T_x_I_win_sum,
  output logic [CNT_W-1:0]                                        row_cnt
);

  localparam int PW = PIXEL_SIZE;
  localparam int PP = 2 * PIXEL_SIZE;

  logic                                      valid_m;
  logic [LINE_SIZE-1:0][PW-1:0]              pix_m;
  logic [LINE_SIZE-1:0][PP-1:0]              sq_m;
  logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][PP-1:0] tx_m;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_m <= 1'b0;
      pix_m   <= '0;
      sq_m    <= '0;
      tx_m    <= '0;
    end else begin
      valid_m <= in_valid & ~in_clear;
      for (int p = 0; p < LINE_SIZE; p++) begin
        pix_m[p] <= I_in_line[p];
        sq_m[p]  <= PP'(I_in_line[p]) * PP'(I_in_line[p]);
        for (int t = 0; t < NUM_TEMPLATES; t++) begin
          tx_m[t][p] <= PP'(T_in_line[t][p]) * PP'(I_in_line[p]);
        end
      end
    end
  end

  logic [PW+DEPTH-1:0]                        i_line;
  logic [LINE_SUM_W-1:0]                      sq_line;
  logic [NUM_TEMPLATES-1:0][LINE_SUM_W-1:0]   tx_line;
  logic [NUM_TEMPLATES+1:0]                   tree_v;
  logic                                       line_valid;

  pipelined_adder_tree #(.IN_W(PW), .N(LINE_SIZE)) u_i_tree (
    .clk(CLK), .rst(RST), .clear(in_clear), .in_valid(valid_m),
    .in_data(pix_m), .out_valid(tree_v[0]), .out_sum(i_line)
  );

  pipelined_adder_tree #(.IN_W(PP), .N(LINE_SIZE)) u_sq_tree (
    .clk(CLK), .rst(RST), .clear(in_clear), .in_valid(valid_m),
    .in_data(sq_m), .out_valid(tree_v[1]), .out_sum(sq_line)
  );

  for (genvar t = 0; t < NUM_TEMPLATES; t++) begin : g_tx
    pipelined_adder_tree #(.IN_W(PP), .N(LINE_SIZE)) u_tx_tree (
      .clk(CLK), .rst(RST), .clear(in_clear), .in_valid(valid_m),
      .in_data(tx_m[t]), .out_valid(tree_v[2+t]), .out_sum(tx_line[t])
    );
  end

  // All trees share one valid path, so they always agree.
  assign line_valid = &tree_v;

  logic [WIN_SUM_W-1:0]                      acc_i, acc_sq;
  logic [NUM_TEMPLATES-1:0][WIN_SUM_W-1:0]   acc_tx;
  logic [WIN_SUM_W-1:0]                      nxt_i, nxt_sq;
  logic [NUM_TEMPLATES-1:0][WIN_SUM_W-1:0]   nxt_tx;
  logic                                      first_row, last_row;

  always_comb begin
    first_row = (row_cnt == '0);
    last_row  = (row_cnt == CNT_W'(WINDOW_ROWS - 1));
    nxt_i     = (first_row ? '0 : acc_i) + WIN_SUM_W'(i_line);
    nxt_sq    = (first_row ? '0 : acc_sq) + WIN_SUM_W'(sq_line);
    nxt_tx    = '0;
    for (int t = 0; t < NUM_TEMPLATES; t++) begin
      nxt_tx[t] = (first_row ? '0 : acc_tx[t]) + WIN_SUM_W'(tx_line[t]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_i            <= '0;
      acc_sq           <= '0;
      acc_tx           <= '0;
      row_cnt          <= '0;
      out_valid        <= 1'b0;
      I_win_sum        <= '0;
      I_square_win_sum <= '0;
      T_x_I_win_sum    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_clear) begin
        acc_i   <= '0;
        acc_sq  <= '0;
        acc_tx  <= '0;
        row_cnt <= '0;
      end else if (line_valid) begin
        if (last_row) begin
          I_win_sum        <= nxt_i;
          I_square_win_sum <= nxt_sq;
          T_x_I_win_sum    <= nxt_tx;
          out_valid        <= 1'b1;
          row_cnt          <= '0;
        end else begin
          acc_i   <= nxt_i;
          acc_sq  <= nxt_sq;
          acc_tx  <= nxt_tx;
          row_cnt <= row_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
